// File: rtl/score_sequencer_if.sv
// Handshake to the shared increment_bcd unit: start/operand out, busy/result back.
interface score_sequencer_if;
  logic        inc_start;
  logic [31:0] inc_bcd_in;
  logic        inc_busy;
  logic [31:0] inc_bcd_out;

  modport master (output inc_start, inc_bcd_in, input inc_busy, inc_bcd_out);
  modport slave  (input inc_start, inc_bcd_in, output inc_busy, inc_bcd_out);
endinterface

// File: rtl/score_sequencer.sv
// Accumulates score/line increments from game events and feeds them one at a
// time through a shared BCD incrementer, round-robin between the two registers.
module score_sequencer #(
  parameter logic [5:0] RESET_STATE = 6'd1,
  parameter int         PEND_W      = 5
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [5:0]               game_state,
  input  logic                     clear_valid,
  input  logic [2:0]               clear_lines,
  input  logic                     drop_valid,
  score_sequencer_if.master        inc,
  output logic [31:0]              score_bcd,
  output logic [31:0]              lines_bcd,
  output logic                     idle,
  output logic                     overflow
);

  localparam logic [31:0]   BCD_RST  = 32'hAAAAAAA0;
  localparam int            SW       = PEND_W + 4;
  localparam logic [SW-1:0] PEND_MAX = SW'({PEND_W{1'b1}});

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t              state, state_nxt;
  logic [PEND_W-1:0]   score_pend, lines_pend;
  logic                tgt_lines, rr_lines, pick_lines;
  logic [1:0]          wb_cnt;
  logic                game_clr, capture;
  logic [3:0]          score_add, lines_add;
  logic                score_dec, lines_dec;
  logic [SW-1:0]       score_sum, lines_sum;
  logic                score_sat, lines_sat;

  assign game_clr  = (game_state == RESET_STATE);
  assign capture   = (state == WAIT_DONE) && !inc.inc_busy;
  assign score_dec = capture && !tgt_lines;
  assign lines_dec = capture &&  tgt_lines;

  // Round-robin only matters when both counters have work queued.
  assign pick_lines = (score_pend != '0 && lines_pend != '0) ? rr_lines
                                                             : (lines_pend != '0);

  always_comb begin
    score_add = '0;
    lines_add = '0;
    if (clear_valid && clear_lines >= 3'd1 && clear_lines <= 3'd4) begin
      lines_add = {1'b0, clear_lines};
      case (clear_lines)
        3'd1:    score_add = 4'd1;
        3'd2:    score_add = 4'd3;
        3'd3:    score_add = 4'd5;
        default: score_add = 4'd8;
      endcase
    end
    if (drop_valid) score_add = score_add + 4'd1;
  end

  // Add and decrement net in one cycle; a decrement only happens on a nonzero target.
  always_comb begin
    score_sum = SW'(score_pend) + SW'(score_add) - SW'(score_dec);
    lines_sum = SW'(lines_pend) + SW'(lines_add) - SW'(lines_dec);
    score_sat = score_sum > PEND_MAX;
    lines_sat = lines_sum > PEND_MAX;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (game_clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (score_pend != '0 || lines_pend != '0) state_nxt = ISSUE;
        ISSUE:     state_nxt = WAIT_BUSY;
        WAIT_BUSY: if (inc.inc_busy)           state_nxt = WAIT_DONE;
                   else if (wb_cnt == 2'd3)    state_nxt = IDLE;
        WAIT_DONE: if (!inc.inc_busy)          state_nxt = GAP;
        GAP:       state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      score_pend <= '0;
      lines_pend <= '0;
      overflow   <= 1'b0;
      score_bcd  <= BCD_RST;
      lines_bcd  <= BCD_RST;
      rr_lines   <= 1'b0;
      tgt_lines  <= 1'b0;
      wb_cnt     <= '0;
    end else if (game_clr) begin
      score_pend <= '0;
      lines_pend <= '0;
      overflow   <= 1'b0;
      score_bcd  <= BCD_RST;
      lines_bcd  <= BCD_RST;
      rr_lines   <= 1'b0;
      tgt_lines  <= 1'b0;
      wb_cnt     <= '0;
    end else begin
      score_pend <= score_sat ? PEND_MAX[PEND_W-1:0] : score_sum[PEND_W-1:0];
      lines_pend <= lines_sat ? PEND_MAX[PEND_W-1:0] : lines_sum[PEND_W-1:0];
      if (score_sat || lines_sat) overflow <= 1'b1;
      if (state == IDLE) tgt_lines <= pick_lines;
      wb_cnt <= (state == WAIT_BUSY) ? wb_cnt + 2'd1 : 2'd0;
      if (capture) begin
        if (tgt_lines) lines_bcd <= inc.inc_bcd_out;
        else           score_bcd <= inc.inc_bcd_out;
        rr_lines <= !tgt_lines;
      end
    end
  end

  // Start and operand decode straight from state so an async reset drops them at once.
  always_comb begin
    inc.inc_start  = (state == ISSUE);
    inc.inc_bcd_in = '0;
    if (state == ISSUE || state == WAIT_BUSY || state == WAIT_DONE)
      inc.inc_bcd_in = tgt_lines ? lines_bcd : score_bcd;
  end

  assign idle = (state == IDLE) && (score_pend == '0) && (lines_pend == '0);

endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer with a behavioural increment_bcd stub.
module tb_score_sequencer;

  localparam logic [5:0]  RST_ST = 6'd1;
  localparam logic [31:0] BLANK0 = 32'hAAAAAAA0;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [5:0]  game_state;
  logic        clear_valid, drop_valid;
  logic [2:0]  clear_lines;
  logic [31:0] score_bcd, lines_bcd;
  logic        idle, overflow;

  logic        stall, never_busy;
  int unsigned lat_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  score_sequencer_if ifc();

  score_sequencer #(.RESET_STATE(RST_ST), .PEND_W(5)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .game_state(game_state),
    .clear_valid(clear_valid), .clear_lines(clear_lines), .drop_valid(drop_valid),
    .inc(ifc), .score_bcd(score_bcd), .lines_bcd(lines_bcd),
    .idle(idle), .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] bcd_inc(input logic [31:0] v);
    logic [31:0] r;
    logic [3:0]  d;
    logic        carry;
    r = v;
    carry = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (carry) begin
        d = r[4*i +: 4];
        if (d == 4'hA) d = 4'd0;
        if (d == 4'd9) begin d = 4'd0; carry = 1'b1; end
        else begin d = d + 4'd1; carry = 1'b0; end
        r[4*i +: 4] = d;
      end
    end
    return r;
  endfunction

  // Increment unit stub: busy for two cycles after start unless stalled or mute.
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ifc.inc_busy    <= 1'b0;
      ifc.inc_bcd_out <= '0;
      lat_cnt         <= 0;
    end else if (ifc.inc_start && !never_busy) begin
      ifc.inc_busy    <= 1'b1;
      ifc.inc_bcd_out <= bcd_inc(ifc.inc_bcd_in);
      lat_cnt         <= 2;
    end else if (ifc.inc_busy && !stall) begin
      if (lat_cnt <= 1) ifc.inc_busy <= 1'b0;
      else              lat_cnt <= lat_cnt - 1;
    end
  end

  // Records which register each capture updated.
  logic [31:0] prev_s, prev_l;
  byte         order_q[$];
  always @(negedge clk_in) begin
    if (rst_n_in === 1'b1) begin
      if (score_bcd !== prev_s) order_q.push_back("S");
      if (lines_bcd !== prev_l) order_q.push_back("L");
    end
    prev_s = score_bcd;
    prev_l = lines_bcd;
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    game_state = 6'd0;
    clear_valid = 1'b0; clear_lines = 3'd0; drop_valid = 1'b0;
    stall = 1'b0; never_busy = 1'b0;
    repeat (2) step();
    rst_n_in = 1'b1;
    step();
    order_q.delete();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (idle !== 1'b1 && n < budget) begin step(); n++; end
    n_checks++;
    if (idle !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: idle not reached within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (score_bcd !== BLANK0) begin n_fail++; $display("FAIL reset_score: got %h want %h", score_bcd, BLANK0); end
    n_checks++; if (lines_bcd !== BLANK0) begin n_fail++; $display("FAIL reset_lines: got %h want %h", lines_bcd, BLANK0); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_checks++; if (ifc.inc_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", ifc.inc_start); end
    n_checks++; if (ifc.inc_bcd_in !== 32'd0) begin n_fail++; $display("FAIL reset_operand: got %h want 0", ifc.inc_bcd_in); end
  endtask

  task automatic test_four_lines();
    logic [95:0] got;
    do_reset();
    clear_valid = 1'b1; clear_lines = 3'd4;
    step();
    clear_valid = 1'b0; clear_lines = 3'd0;
    wait_idle(400, "four_lines_done");
    step();
    got = '0;
    foreach (order_q[i]) got = {got[87:0], order_q[i]};
    n_checks++; if (order_q.size() != 12) begin n_fail++; $display("FAIL four_lines_count: got %0d want 12", order_q.size()); end
    n_checks++; if (got !== "SLSLSLSLSSSS") begin n_fail++; $display("FAIL four_lines_order: got %s want SLSLSLSLSSSS", got); end
    n_checks++; if (score_bcd !== 32'hAAAAAAA8) begin n_fail++; $display("FAIL four_lines_score: got %h want AAAAAAA8", score_bcd); end
    n_checks++; if (lines_bcd !== 32'hAAAAAAA4) begin n_fail++; $display("FAIL four_lines_lines: got %h want AAAAAAA4", lines_bcd); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL four_lines_idle: got %b want 1", idle); end
  endtask

  task automatic test_clear_and_drop();
    do_reset();
    clear_valid = 1'b1; clear_lines = 3'd2; drop_valid = 1'b1;
    step();
    clear_valid = 1'b0; clear_lines = 3'd0; drop_valid = 1'b0;
    n_checks++; if (dut.score_pend !== 5'd4) begin n_fail++; $display("FAIL both_score_pend: got %0d want 4", dut.score_pend); end
    n_checks++; if (dut.lines_pend !== 5'd2) begin n_fail++; $display("FAIL both_lines_pend: got %0d want 2", dut.lines_pend); end
    wait_idle(200, "both_done");
    n_checks++; if (score_bcd !== 32'hAAAAAAA4) begin n_fail++; $display("FAIL both_score: got %h want AAAAAAA4", score_bcd); end
    n_checks++; if (lines_bcd !== 32'hAAAAAAA2) begin n_fail++; $display("FAIL both_lines: got %h want AAAAAAA2", lines_bcd); end
  endtask

  task automatic test_ignored_lines();
    do_reset();
    clear_valid = 1'b1; clear_lines = 3'd0;
    step();
    clear_lines = 3'd5;
    step();
    clear_valid = 1'b0; clear_lines = 3'd0;
    n_checks++; if (dut.score_pend !== 5'd0 || dut.lines_pend !== 5'd0) begin
      n_fail++; $display("FAIL ignored_pend: got %0d/%0d want 0/0", dut.score_pend, dut.lines_pend); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL ignored_idle: got %b want 1", idle); end
  endtask

  task automatic test_saturate();
    do_reset();
    stall = 1'b1;
    drop_valid = 1'b1;
    repeat (40) step();
    drop_valid = 1'b0;
    n_checks++; if (dut.score_pend !== 5'd31) begin n_fail++; $display("FAIL sat_pend: got %0d want 31", dut.score_pend); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b want 1", overflow); end
    stall = 1'b0;
    wait_idle(2000, "sat_done");
    n_checks++; if (score_bcd !== 32'hAAAAAA31) begin n_fail++; $display("FAIL sat_score: got %h want AAAAAA31", score_bcd); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_no_busy();
    int starts[$];
    do_reset();
    never_busy = 1'b1;
    drop_valid = 1'b1;
    step();
    drop_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ifc.inc_start === 1'b1) starts.push_back(c);
    end
    n_checks++; if (starts.size() < 3) begin n_fail++; $display("FAIL retry_count: got %0d starts want >=3", starts.size()); end
    else begin
      n_checks++; if (starts[1] - starts[0] != 6) begin n_fail++; $display("FAIL retry_gap1: got %0d want 6", starts[1] - starts[0]); end
      n_checks++; if (starts[2] - starts[1] != 6) begin n_fail++; $display("FAIL retry_gap2: got %0d want 6", starts[2] - starts[1]); end
    end
    n_checks++; if (dut.score_pend !== 5'd1) begin n_fail++; $display("FAIL retry_pend: got %0d want 1", dut.score_pend); end
    n_checks++; if (score_bcd !== BLANK0) begin n_fail++; $display("FAIL retry_score: got %h want %h", score_bcd, BLANK0); end
    game_state = RST_ST;
    step();
    game_state = 6'd0;
    never_busy = 1'b0;
    n_checks++; if (idle !== 1'b1 || dut.score_pend !== 5'd0) begin
      n_fail++; $display("FAIL retry_clear: got idle=%b pend=%0d want idle=1 pend=0", idle, dut.score_pend); end
  endtask

  task automatic test_clear_in_wait_done();
    int n = 0;
    do_reset();
    stall = 1'b1;
    drop_valid = 1'b1;
    step();
    drop_valid = 1'b0;
    while (ifc.inc_busy !== 1'b1 && n < 20) begin step(); n++; end
    n_checks++; if (ifc.inc_busy !== 1'b1) begin n_fail++; $display("FAIL gclr_busy: unit never went busy"); end
    repeat (2) step();
    game_state = RST_ST;
    drop_valid = 1'b1;
    step();
    game_state = 6'd0;
    drop_valid = 1'b0;
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL gclr_idle: got %b want 1", idle); end
    n_checks++; if (dut.score_pend !== 5'd0) begin n_fail++; $display("FAIL gclr_pend: got %0d want 0", dut.score_pend); end
    stall = 1'b0;
    repeat (10) step();
    n_checks++; if (score_bcd !== BLANK0) begin n_fail++; $display("FAIL gclr_score: got %h want %h", score_bcd, BLANK0); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL gclr_idle_after: got %b want 1", idle); end
  endtask

  task automatic test_async_reset();
    int n = 0;
    do_reset();
    clear_valid = 1'b1; clear_lines = 3'd1;
    step();
    clear_valid = 1'b0; clear_lines = 3'd0;
    wait_idle(100, "async_prep");
    drop_valid = 1'b1;
    step();
    drop_valid = 1'b0;
    while (ifc.inc_start !== 1'b1 && n < 10) begin step(); n++; end
    n_checks++; if (ifc.inc_start !== 1'b1) begin n_fail++; $display("FAIL async_issue: never reached ISSUE"); end
    #2 rst_n_in = 1'b0;
    #1;
    n_checks++; if (ifc.inc_start !== 1'b0) begin n_fail++; $display("FAIL async_start: got %b want 0", ifc.inc_start); end
    n_checks++; if (ifc.inc_bcd_in !== 32'd0) begin n_fail++; $display("FAIL async_operand: got %h want 0", ifc.inc_bcd_in); end
    n_checks++; if (score_bcd !== BLANK0 || lines_bcd !== BLANK0) begin
      n_fail++; $display("FAIL async_regs: got %h/%h want %h", score_bcd, lines_bcd, BLANK0); end
    n_checks++; if (idle !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL async_flags: got idle=%b ovf=%b want 1/0", idle, overflow); end
    step();
    rst_n_in = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_four_lines();
    test_clear_and_drop();
    test_ignored_lines();
    test_saturate();
    test_no_busy();
    test_clear_in_wait_done();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_sequencer.md
SCORE_SEQUENCER -- requirements
Module: score_sequencer

Interface
REQ-001 SHALL have parameter RESET_STATE, default 6'd1, the game_state encoding that clears all scoring.
REQ-002 SHALL have parameter PEND_W, default 5, the width of each pending-increment counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: clk_in  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have rst_n_in  input  1  asynchronous active-low reset.
REQ-005 SHALL have game_state  input  6  game FSM state; equal to RESET_STATE means synchronous game clear.
REQ-006 SHALL have clear_valid  input  1  one-cycle line-clear event.
REQ-007 SHALL have clear_lines  input  3  lines cleared with the event, 1..4; 0 or >4 ignored.
REQ-008 SHALL have drop_valid  input  1  one-cycle hard-drop bonus event, worth 1 score increment.
REQ-009 SHALL have inc_start  output  1  start pulse to the shared increment_bcd unit.
REQ-010 SHALL have inc_bcd_in  output  32  operand to the increment unit, 8 BCD digits, 0xA = blank.
REQ-011 SHALL have inc_busy  input  1  increment unit busy.
REQ-012 SHALL have inc_bcd_out  input  32  increment unit result.
REQ-013 SHALL have score_bcd  output  32  displayed score.
REQ-014 SHALL have lines_bcd  output  32  displayed line count.
REQ-015 SHALL have idle  output  1  high when no increments are pending and the FSM is in IDLE.
REQ-016 SHALL have overflow  output  1  sticky flag: a pending counter saturated.

Function
REQ-017 SHALL keep two pending counters: score_pend and lines_pend, each PEND_W bits.
REQ-018 On a valid clear_valid, lines_pend SHALL add clear_lines, and score_pend SHALL add 1/3/5/8 for 1/2/3/4 lines.
REQ-019 drop_valid SHALL add 1 to score_pend; simultaneous clear_valid and drop_valid SHALL sum in the same cycle.
REQ-020 An addition coinciding with a decrement on the same counter SHALL net both in that cycle.
REQ-021 Counters SHALL saturate at 2^PEND_W-1; any saturated addition SHALL set overflow, which clears only on reset or game clear.
REQ-022 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
REQ-023 In IDLE with a nonzero pending counter, the FSM SHALL select a target and go to ISSUE next cycle.
REQ-024 When both counters are nonzero, target selection SHALL be round-robin, starting with score after reset and alternating after each completed increment.
REQ-025 In ISSUE, inc_start SHALL be high for exactly one cycle, with inc_bcd_in = the target register; the FSM then goes to WAIT_BUSY.
REQ-026 In WAIT_BUSY, inc_busy high SHALL move the FSM to WAIT_DONE.
REQ-027 In WAIT_BUSY, inc_busy still low after 4 cycles SHALL return the FSM to IDLE with nothing captured and the pending count kept (retry).
REQ-028 In WAIT_DONE, inc_busy low SHALL capture inc_bcd_out into the target register, decrement its pending counter by 1, and move the FSM to GAP.
REQ-029 GAP SHALL last exactly 1 cycle, then IDLE; the minimum start-to-start spacing is therefore ISSUE + unit latency + 2 cycles.
REQ-030 inc_bcd_in SHALL hold its value from ISSUE through WAIT_DONE; it SHALL be 0 otherwise.
REQ-031 score_bcd and lines_bcd SHALL change only on capture or clear.
REQ-032 The block SHALL NOT inspect BCD digits; digit wrap at 99999999 is the increment unit's behaviour and is passed through.
REQ-033 idle SHALL be combinational: state==IDLE and both counters zero.

Reset
REQ-034 rst_n_in low SHALL asynchronously force: FSM IDLE, both counters 0, overflow 0, inc_start 0, inc_bcd_in 0, score_bcd = lines_bcd = 32'hAAAAAAA0, round-robin pointer = score.
REQ-035 game_state==RESET_STATE SHALL apply the same values on the next clock edge, aborting any in-flight increment and discarding its result.
REQ-036 Events in a game-clear cycle SHALL be dropped.

Verification
REQ-037 After reset, pulse clear_valid with clear_lines=4 -> 8 score and 4 lines increments, interleaved S,L,S,L,S,L,S,L,S,S,S,S; final score_bcd=AAAAAAA8, lines_bcd=AAAAAAA4, idle=1.
REQ-038 clear_valid(2) and drop_valid in the same cycle -> score_pend=4, lines_pend=2; final score AAAAAAA4, lines AAAAAAA2.
REQ-039 Inject 40 drop_valid pulses while a stub unit stalls busy -> score_pend saturates at 31, overflow=1, final score_bcd=AAAAAA31.
REQ-040 Stub unit never raises busy -> inc_start re-pulses every 6 cycles, pending count unchanged, registers unchanged.
REQ-041 game_state=RESET_STATE during WAIT_DONE -> registers reset; the late inc_bcd_out is not captured; idle=1 next cycle.
REQ-042 rst_n_in low mid-ISSUE, asynchronously -> inc_start drops immediately without waiting for a clock, and all outputs are at reset values.
